// File: rtl/alu_pkg.sv
// Shared funct codes and FSM state type for alu_pipe.
// ALU_PIPE_MUL_EN adds the MUL state used by the iterative multiplier.
package alu_pkg;

    localparam logic [5:0] OpAdd  = 6'b100000;
    localparam logic [5:0] OpAddu = 6'b100001;
    localparam logic [5:0] OpSub  = 6'b100010;
    localparam logic [5:0] OpSubu = 6'b100011;
    localparam logic [5:0] OpAnd  = 6'b100100;
    localparam logic [5:0] OpOr   = 6'b100101;
    localparam logic [5:0] OpXor  = 6'b100110;
    localparam logic [5:0] OpNor  = 6'b100111;
    localparam logic [5:0] OpSll  = 6'b000000;
    localparam logic [5:0] OpSrl  = 6'b000010;
    localparam logic [5:0] OpSra  = 6'b000011;
    localparam logic [5:0] OpSlt  = 6'b101010;
    localparam logic [5:0] OpSltu = 6'b101011;
    localparam logic [5:0] OpMult = 6'b011000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
`ifdef ALU_PIPE_MUL_EN
        StMul  = 2'd1,
`endif
        StOut  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Signed iterative shift-add multiplier: one partial product per cycle, WORD_WIDTH cycles.
// done is high during the final iteration; product then carries the completed result.
module alu_mul_iter #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORD_WIDTH-1:0]     a,
    input  logic [WORD_WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*WORD_WIDTH-1:0]   product
);

    localparam int unsigned CNT_WIDTH = $clog2(WORD_WIDTH);

    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [2*WORD_WIDTH-1:0] acc_q, acc_d;
    logic [2*WORD_WIDTH-1:0] mcand_q;
    logic [2*WORD_WIDTH-1:0] addend;
    logic [WORD_WIDTH-1:0]   mplier_q;
    logic                    last;

    assign last = (cnt_q == CNT_WIDTH'(WORD_WIDTH - 1));

    // The multiplier's sign bit has weight -2^(W-1), so the last step subtracts.
    always_comb begin
        addend = '0;
        if (mplier_q[0]) begin
            addend = last ? (~mcand_q + 1'b1) : mcand_q;
        end
        acc_d = acc_q + addend;
    end

    assign done    = busy_q && last;
    assign product = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WORD_WIDTH{a[WORD_WIDTH-1]}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops with 1-cycle latency, registered results and flags.
// Define ALU_PIPE_MUL_EN to add signed MULT via the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] a_input,
    input  logic [WORD_WIDTH-1:0] b_input,
    input  logic [5:0]            opcode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] resultado,
    output logic [WORD_WIDTH-1:0] result_hi,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero,
    output logic                  illegal
);

    alu_state_e state_q, state_d, accept_state;

    logic                  accept;
    logic                  is_mult;
    logic [WORD_WIDTH:0]   add_sum;
    logic [WORD_WIDTH:0]   sub_diff;
    logic                  add_ovf, sub_ovf;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [WORD_WIDTH-1:0] alu_lo;
    logic                  alu_carry, alu_ovf, alu_illegal;

    logic [WORD_WIDTH-1:0] resultado_q, result_hi_q;
    logic                  carry_q, ovf_q, zero_q, illegal_q;

    assign in_ready  = (state_q == StIdle) || ((state_q == StOut) && out_ready);
    assign out_valid = (state_q == StOut);
    assign accept    = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    logic                    mul_done;
    logic [2*WORD_WIDTH-1:0] mul_product;

    assign is_mult      = (opcode == OpMult);
    assign accept_state = is_mult ? StMul : StOut;

    alu_mul_iter #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mult),
        .a       (a_input),
        .b       (b_input),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mult      = 1'b0;
    assign accept_state = StOut;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = accept_state;
`ifdef ALU_PIPE_MUL_EN
            StMul:  if (mul_done) state_d = StOut;
`endif
            StOut:  if (out_ready) state_d = accept ? accept_state : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Carry is the unsigned carry for adds; for subtracts bit W of the widened difference is the borrow.
    assign add_sum  = {1'b0, a_input} + {1'b0, b_input};
    assign sub_diff = {1'b0, a_input} - {1'b0, b_input};
    assign add_ovf  = (a_input[WORD_WIDTH-1] == b_input[WORD_WIDTH-1]) &&
                      (add_sum[WORD_WIDTH-1] != a_input[WORD_WIDTH-1]);
    assign sub_ovf  = (a_input[WORD_WIDTH-1] != b_input[WORD_WIDTH-1]) &&
                      (sub_diff[WORD_WIDTH-1] != a_input[WORD_WIDTH-1]);
    assign shamt    = b_input[SHAMT_WIDTH-1:0];

    always_comb begin
        alu_lo      = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (opcode)
            OpAdd: begin
                alu_lo    = add_sum[WORD_WIDTH-1:0];
                alu_carry = add_sum[WORD_WIDTH];
                alu_ovf   = add_ovf;
            end
            OpAddu: begin
                alu_lo    = add_sum[WORD_WIDTH-1:0];
                alu_carry = add_sum[WORD_WIDTH];
            end
            OpSub: begin
                alu_lo    = sub_diff[WORD_WIDTH-1:0];
                alu_carry = sub_diff[WORD_WIDTH];
                alu_ovf   = sub_ovf;
            end
            OpSubu: begin
                alu_lo    = sub_diff[WORD_WIDTH-1:0];
                alu_carry = sub_diff[WORD_WIDTH];
            end
            OpAnd:  alu_lo = a_input & b_input;
            OpOr:   alu_lo = a_input | b_input;
            OpXor:  alu_lo = a_input ^ b_input;
            OpNor:  alu_lo = ~(a_input | b_input);
            OpSll:  alu_lo = a_input << shamt;
            OpSrl:  alu_lo = a_input >> shamt;
            OpSra:  alu_lo = $unsigned($signed(a_input) >>> shamt);
            OpSlt:  alu_lo[0] = $signed(a_input) < $signed(b_input);
            OpSltu: alu_lo[0] = a_input < b_input;
`ifdef ALU_PIPE_MUL_EN
            OpMult: alu_illegal = 1'b0;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    // Result registers only load on an accept or multiplier completion, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado_q <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept && !is_mult) begin
            resultado_q <= alu_lo;
            result_hi_q <= '0;
            carry_q     <= alu_carry;
            ovf_q       <= alu_ovf;
            zero_q      <= (alu_lo == '0);
            illegal_q   <= alu_illegal;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (state_q == StMul && mul_done) begin
            resultado_q <= mul_product[WORD_WIDTH-1:0];
            result_hi_q <= mul_product[2*WORD_WIDTH-1:WORD_WIDTH];
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (mul_product == '0);
            illegal_q   <= 1'b0;
        end
`endif
    end

    assign resultado = resultado_q;
    assign result_hi = result_hi_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe; MULT scenarios run when ALU_PIPE_MUL_EN is defined.
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_MULT = 6'b011000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a_input = '0, b_input = '0;
    logic [5:0]  opcode = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] resultado, result_hi;
    logic        carry_out, overflow, zero, illegal;

    always #5 clk = ~clk;

    alu_pipe #(
        .WORD_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_input   (a_input),
        .b_input   (b_input),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .result_hi (result_hi),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        c;
        logic        v;
        logic        z;
        logic        il;
    } res_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t   op_q[$];
    res_t  exp_q[$];
    res_t  got_q[$];
    string name_q[$];
    int    acc_cyc[$];
    int    got_cyc[$];
    int    total = 0;
    int    bad = 0;

    function automatic res_t r(input logic [31:0] lo, input logic [31:0] hi,
                               input logic c, input logic v, input logic z, input logic il);
        return {lo, hi, c, v, z, il};
    endfunction

    task automatic push(input string nm, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input res_t e);
        op_q.push_back({op, a, b});
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive_front();
        if (op_q.size() > 0) begin
            in_valid = 1'b1;
            opcode   = op_q[0].op;
            a_input  = op_q[0].a;
            b_input  = op_q[0].b;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Streams queued ops with out_ready high, capturing every result and its cycle.
    task automatic run_ops(input int budget);
        int   n_exp;
        int   cyc;
        logic acc;
        n_exp = exp_q.size();
        cyc = 0;
        acc_cyc.delete();
        got_cyc.delete();
        got_q.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_front();
        while (got_q.size() < n_exp && cyc < budget) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got_q.push_back(r(resultado, result_hi, carry_out, overflow, zero, illegal));
                got_cyc.push_back(cyc);
            end
            acc = in_valid && in_ready;
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            cyc++;
            if (acc) void'(op_q.pop_front());
            drive_front();
        end
        in_valid = 1'b0;
        op_q.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid);
        end
        total++;
        if ({resultado, result_hi} !== 64'd0) begin
            bad++; $display("FAIL reset_results: got %h/%h need 0/0", resultado, result_hi);
        end
        total++;
        if ({carry_out, overflow, zero, illegal} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got cvzi=%b%b%b%b need 0000",
                            carry_out, overflow, zero, illegal);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_arith();
        res_t e, g; string nm;
        push("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, r(32'h8000_0000, 0, 0, 1, 0, 0));
        push("addu_wrap", F_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, r(32'h0, 0, 1, 0, 1, 0));
        push("add_neg", F_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r(32'hFFFF_FFFE, 0, 1, 0, 0, 0));
        push("sub_ovf", F_SUB, 32'h8000_0000, 32'h0000_0001, r(32'h7FFF_FFFF, 0, 0, 1, 0, 0));
        push("subu_borrow", F_SUBU, 32'h3, 32'h5, r(32'hFFFF_FFFE, 0, 1, 0, 0, 0));
        push("slt", F_SLT, 32'hFFFF_FFFB, 32'h3, r(32'h1, 0, 0, 0, 0, 0));
        push("sltu", F_SLTU, 32'hFFFF_FFFB, 32'h3, r(32'h0, 0, 0, 0, 1, 0));
        run_ops(50);
        total++;
        if (acc_cyc.size() == 0 || got_cyc.size() == 0 || got_cyc[0] - acc_cyc[0] != 1) begin
            bad++; $display("FAIL add_latency: got %0d results need latency 1", got_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); total++;
            if (got_q.size() == 0) begin
                bad++; $display("FAIL %s: no result, need lo=%h", nm, e.lo);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    bad++; $display("FAIL %s: got lo/hi/cvzi=%h/%h/%b need %h/%h/%b", nm,
                                    g.lo, g.hi, {g.c, g.v, g.z, g.il}, e.lo, e.hi, {e.c, e.v, e.z, e.il});
                end
            end
        end
    endtask

    task automatic test_shift_logic();
        res_t e, g; string nm;
        push("sll_31", F_SLL, 32'h0000_0001, 32'hFFFF_FFFF, r(32'h8000_0000, 0, 0, 0, 0, 0));
        push("srl_4", F_SRL, 32'h8000_0000, 32'h0000_0024, r(32'h0800_0000, 0, 0, 0, 0, 0));
        push("sra_4", F_SRA, 32'h8000_0000, 32'h0000_0024, r(32'hF800_0000, 0, 0, 0, 0, 0));
        push("sra_pos", F_SRA, 32'h7FFF_FFFF, 32'h0000_0004, r(32'h07FF_FFFF, 0, 0, 0, 0, 0));
        push("and", F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, r(32'hF000_F000, 0, 0, 0, 0, 0));
        push("or", F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, r(32'hFFF0_FFF0, 0, 0, 0, 0, 0));
        push("xor", F_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, r(32'h0FF0_0FF0, 0, 0, 0, 0, 0));
        push("nor", F_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, r(32'h000F_000F, 0, 0, 0, 0, 0));
        run_ops(50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); total++;
            if (got_q.size() == 0) begin
                bad++; $display("FAIL %s: no result, need lo=%h", nm, e.lo);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    bad++; $display("FAIL %s: got lo/hi/cvzi=%h/%h/%b need %h/%h/%b", nm,
                                    g.lo, g.hi, {g.c, g.v, g.z, g.il}, e.lo, e.hi, {e.c, e.v, e.z, e.il});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e, g; string nm;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = F_ADD; a_input = 32'd2; b_input = 32'd2;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_accept: in_ready got %b need 1", in_ready);
        end
        exp_q.push_back(r(32'd4, 0, 0, 0, 0, 0)); name_q.push_back("bp_add_2_2");
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = F_ADD; a_input = 32'd1; b_input = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, resultado, result_hi, carry_out, overflow, zero, illegal}
                !== {1'b1, 1'b0, 32'd4, 32'd0, 4'b0000}) begin
                bad++; $display("FAIL bp_hold%0d: got ov/ir/lo/hi=%b/%b/%h/%h need 1/0/4/0",
                                i, out_valid, in_ready, resultado, result_hi);
            end
        end
        push("bp_add_1_1", F_ADD, 32'd1, 32'd1, r(32'd2, 0, 0, 0, 0, 0));
        push("bp_sub", F_SUB, 32'd10, 32'd3, r(32'd7, 0, 0, 0, 0, 0));
        push("bp_xor", F_XOR, 32'hAAAA_5555, 32'hAAAA_5555, r(32'd0, 0, 0, 0, 1, 0));
        push("bp_or", F_OR, 32'h0000_00F0, 32'h0000_000F, r(32'h0000_00FF, 0, 0, 0, 0, 0));
        run_ops(50);
        total++;
        if (got_cyc.size() != 5 || got_cyc[4] - got_cyc[0] != 4) begin
            bad++; $display("FAIL bp_throughput: got %0d results need 5 in consecutive cycles",
                            got_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); total++;
            if (got_q.size() == 0) begin
                bad++; $display("FAIL %s: no result, need lo=%h", nm, e.lo);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    bad++; $display("FAIL %s: got lo/hi/cvzi=%h/%h/%b need %h/%h/%b", nm,
                                    g.lo, g.hi, {g.c, g.v, g.z, g.il}, e.lo, e.hi, {e.c, e.v, e.z, e.il});
                end
            end
        end
    endtask

    task automatic test_illegal();
        res_t e, g; string nm;
        push("ill_3f", 6'b111111, 32'h1234_5678, 32'h1, r(32'h0, 0, 0, 0, 1, 1));
        push("ill_01", 6'b000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r(32'h0, 0, 0, 0, 1, 1));
        push("legal_after", F_ADDU, 32'h5, 32'h6, r(32'd11, 0, 0, 0, 0, 0));
`ifndef ALU_PIPE_MUL_EN
        push("mult_disabled", F_MULT, 32'h3, 32'h7, r(32'h0, 0, 0, 0, 1, 1));
`endif
        run_ops(50);
        total++;
        if (acc_cyc.size() == 0 || got_cyc.size() == 0 || got_cyc[0] - acc_cyc[0] != 1) begin
            bad++; $display("FAIL ill_latency: got %0d results need latency 1", got_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); total++;
            if (got_q.size() == 0) begin
                bad++; $display("FAIL %s: no result, need lo=%h", nm, e.lo);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    bad++; $display("FAIL %s: got lo/hi/cvzi=%h/%h/%b need %h/%h/%b", nm,
                                    g.lo, g.hi, {g.c, g.v, g.z, g.il}, e.lo, e.hi, {e.c, e.v, e.z, e.il});
                end
            end
        end
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mult();
        res_t e, g; string nm;
        int   lat;
        logic seen_ready;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; opcode = F_MULT; a_input = 32'hFFFF_FFFD; b_input = 32'd7;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL mult_accept: in_ready got %b need 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) seen_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 33) begin
            bad++; $display("FAIL mult_latency: got %0d need 33", lat);
        end
        total++;
        if (seen_ready !== 1'b0) begin
            bad++; $display("FAIL mult_in_ready: got in_ready=1 while busy need 0");
        end
        total++;
        if ({resultado, result_hi, carry_out, overflow, zero, illegal} !==
            {32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b0000}) begin
            bad++; $display("FAIL mult_neg: got %h/%h need ffffffeb/ffffffff", resultado, result_hi);
        end
        push("mult_zero", F_MULT, 32'h0, 32'h5, r(32'h0, 32'h0, 0, 0, 1, 0));
        push("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000, r(32'h0, 32'h4000_0000, 0, 0, 0, 0));
        push("mult_m1", F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r(32'h1, 32'h0, 0, 0, 0, 0));
        push("add_after", F_ADD, 32'h1, 32'h1, r(32'h2, 32'h0, 0, 0, 0, 0));
        run_ops(300);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); total++;
            if (got_q.size() == 0) begin
                bad++; $display("FAIL %s: no result, need lo=%h", nm, e.lo);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    bad++; $display("FAIL %s: got lo/hi/cvzi=%h/%h/%b need %h/%h/%b", nm,
                                    g.lo, g.hi, {g.c, g.v, g.z, g.il}, e.lo, e.hi, {e.c, e.v, e.z, e.il});
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        int seen;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; a_input = 32'd9; b_input = 32'd9;
`ifdef ALU_PIPE_MUL_EN
        opcode = F_MULT;
`else
        opcode = F_ADD;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || resultado !== 32'd0 || in_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_op: got ov=%b lo=%h need 0/0", out_valid, resultado);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL rst_no_result: got %0d cycles of out_valid need 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_logic();
        test_back_to_back();
        test_illegal();
`ifdef ALU_PIPE_MUL_EN
        test_mult();
`endif
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, operand/result width (>=8).
REQ-002 SHALL have parameter SHAMT_WIDTH, default $clog2(WORD_WIDTH), shift-amount bits taken from b_input.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports a_input, b_input  in  WORD_WIDTH  operands; opcode  in  6  funct code.
REQ-006 SHALL have ports in_valid  in  1 and in_ready  out  1, the operation-accept handshake.
REQ-007 SHALL have ports out_valid  out  1 and out_ready  in  1, the result handshake.
REQ-008 SHALL have outputs resultado  WORD_WIDTH, result_hi  WORD_WIDTH, carry_out, overflow, zero, illegal (1 bit each), all registered.

Function
REQ-009 SHALL accept an operation when in_valid&&in_ready; operands/opcode captured that edge.
REQ-010 SHALL use FSM states IDLE, MUL, OUT: IDLE->OUT on single-cycle op accept; IDLE->MUL on MULT accept; MUL->OUT after WORD_WIDTH iterations; OUT->IDLE on out_ready with no accept; OUT->OUT on out_ready with accept of a single-cycle op; OUT->MUL on out_ready with MULT accept.
REQ-011 SHALL drive in_ready = (state==IDLE) || (state==OUT && out_ready); out_valid = (state==OUT).
REQ-012 SHALL give single-cycle ops latency 1: result visible with out_valid the cycle after accept; back-to-back throughput 1/cycle when out_ready held high.
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-014 SHALL implement: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000000 SLL, 000010 SRL, 000011 SRA, 101010 SLT (signed), 101011 SLTU, 011000 MULT.
REQ-015 SHALL set carry_out = unsigned carry for ADD/ADDU, unsigned borrow (a<b) for SUB/SUBU, else 0.
REQ-016 SHALL set overflow = signed overflow for ADD/SUB only; 0 for ADDU/SUBU and all others.
REQ-017 SHALL shift by b_input[SHAMT_WIDTH-1:0] only; SRA sign-fills; upper b bits ignored.
REQ-018 SHALL produce SLT/SLTU result as 1 or 0 zero-extended.
REQ-019 SHALL compute MULT as signed WORD_WIDTH x WORD_WIDTH iterative shift-add, exactly WORD_WIDTH cycles in MUL; low word on resultado, high on result_hi.
REQ-020 SHALL drive result_hi=0 for every non-MULT op.
REQ-021 SHALL set zero = (resultado==0) for the held result (MULT: full 2*WORD_WIDTH product ==0).
REQ-022 SHALL, for undefined opcodes, complete in 1 cycle with resultado=0, result_hi=0, zero=1, illegal=1, carry_out=overflow=0; illegal=0 for defined ops.

Reset
REQ-023 SHALL on rst_n low immediately enter IDLE; out_valid=0, resultado=0, result_hi=0, carry_out=0, overflow=0, zero=0, illegal=0; in_ready=1 after release.
REQ-024 SHALL abandon an in-progress MULT on reset with no result emitted.

Configuration
REQ-025 SHALL use macro ALU_PIPE_MUL_EN: defined -> MULT and MUL state present; undefined -> MUL state and multiplier logic absent, 011000 treated as illegal per REQ-022.

Structure
REQ-026 SHALL place opcode localparams (funct codes) and the FSM state typedef in shared package alu_pkg.
REQ-027 SHALL isolate the iterative multiplier in sub-module alu_mul_iter (start, done, operands, 2*WORD_WIDTH product).

Verification
REQ-028 SHALL check ADD 0x7FFFFFFF+0x00000001 -> resultado 0x80000000, overflow=1, carry_out=0, zero=0, out_valid one cycle after accept.
REQ-029 SHALL check SUBU 0x00000003-0x00000005 -> 0xFFFFFFFE, carry_out=1, overflow=0; SLT -5,3 -> 1; SLTU same -> 0.
REQ-030 SHALL check SRA 0x80000000 by b=0x00000024 -> shift 4 -> 0xF8000000.
REQ-031 SHALL check MULT -3 x 7 (MUL_EN) -> resultado 0xFFFFFFEB, result_hi 0xFFFFFFFF, out_valid exactly 33 cycles after accept, in_ready=0 meanwhile.
REQ-032 SHALL check backpressure: out_ready=0 for 5 cycles after ADD 2+2 -> resultado 4 held, in_ready=0; then stream 4 ops with out_ready=1 -> one result per cycle.
REQ-033 SHALL check opcode 111111 -> illegal=1, zero=1; rst_n low mid-MULT -> out_valid=0 immediately, no result after release.
